// File: rtl/lsu_pkg.sv
// lsu_pkg: op encodings, FSM states and the DM/timer address map for m_lsu.
package lsu_pkg;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } lsu_state_t;

    localparam logic [31:0] DM_START = 32'h0000_0000;
    localparam logic [31:0] DM_END   = 32'h0000_2FFF;
    localparam logic [31:0] T1_START = 32'h0000_7F00;
    localparam logic [31:0] T1_END   = 32'h0000_7F0B;
    localparam logic [31:0] T2_START = 32'h0000_7F10;
    localparam logic [31:0] T2_END   = 32'h0000_7F1B;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    function automatic logic op_is_store(input logic [2:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_LH) || (op == OP_LB);
    endfunction

    function automatic logic [1:0] op_size(input logic [2:0] op);
        case (op)
            OP_LW, OP_SW:         return SZ_W;
            OP_LH, OP_LHU, OP_SH: return SZ_H;
            default:              return SZ_B;
        endcase
    endfunction

endpackage

// File: rtl/m_lsu_ext.sv
// lsu_ext: selects the addressed lane of captured bus read data and sign/zero extends it.
module lsu_ext
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]             rdata,
    input  logic [2:0]                    op,
    input  logic [$clog2(DATA_W/8)-1:0]   off,
    output logic [31:0]                   ext
);

    logic [31:0] lane;
    logic        sgn;

    always_comb begin
        // byte offset shift also picks the upper word of a 64-bit bus for LW
        lane = 32'(rdata >> {off, 3'b000});
        sgn  = op_is_signed(op);
        ext  = '0;
        case (op_size(op))
            SZ_W:    ext = lane;
            SZ_H:    ext = {{16{sgn & lane[15]}}, lane[15:0]};
            default: ext = {{24{sgn & lane[7]}}, lane[7:0]};
        endcase
    end

endmodule

// File: rtl/m_lsu.sv
// m_lsu: M-stage load/store unit with AdEL/AdES checks and a registered multi-cycle bus port.
// Define M_LSU_TIMER_GUARD_EN to reject sub-word accesses at or above T1_START.
module m_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    input  logic [2:0]            req_op,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  req_ready,
    input  logic                  flush,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  exc_adel,
    output logic                  exc_ades,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W/8-1:0]   bus_be,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_W-1:0]     bus_rdata
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    lsu_state_t        state, state_nx;
    logic [OFF_W-1:0]  off_q;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] rdata_q;
    logic              exc_l_q, exc_s_q, killed;

    logic              accept, misalign, out_of_range, guard_err, acc_err;
    logic [1:0]        sz;
    logic [OFF_W-1:0]  off;
    logic [NB-1:0]     be_nx;
    logic [DATA_W-1:0] wdata_nx;
    logic [31:0]       ext_data;

    function automatic logic in_win(input logic [ADDR_W-1:0] a,
                                    input logic [31:0] lo, input logic [31:0] hi);
        return (a - ADDR_W'(lo)) <= ADDR_W'(hi - lo);
    endfunction

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready && !flush;

    always_comb begin
        sz       = op_size(req_op);
        off      = req_addr[OFF_W-1:0];
        misalign = ((sz == SZ_W) && (req_addr[1:0] != 2'b00)) ||
                   ((sz == SZ_H) && req_addr[0]);
        out_of_range = !(in_win(req_addr, DM_START, DM_END) ||
                         in_win(req_addr, T1_START, T1_END) ||
                         in_win(req_addr, T2_START, T2_END));
`ifdef M_LSU_TIMER_GUARD_EN
        guard_err = (sz != SZ_W) && (req_addr >= ADDR_W'(T1_START));
`else
        guard_err = 1'b0;
`endif
        acc_err = misalign || out_of_range || guard_err;

        be_nx    = '0;
        wdata_nx = '0;
        case (sz)
            SZ_W: begin
                be_nx    = NB'(4'hF) << off;
                wdata_nx = {(DATA_W/32){req_wdata}};
            end
            SZ_H: begin
                be_nx    = NB'(2'b11) << off;
                wdata_nx = {(DATA_W/16){req_wdata[15:0]}};
            end
            default: begin
                be_nx    = NB'(1'b1) << off;
                wdata_nx = {NB{req_wdata[7:0]}};
            end
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = acc_err ? S_RESP : S_BUSY;
            // a killed transaction still waits for ack, then skips the response
            S_BUSY:  if (bus_ack) state_nx = (killed || flush) ? S_IDLE : S_RESP;
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            off_q     <= '0;
            op_q      <= OP_LW;
            rdata_q   <= '0;
            exc_l_q   <= 1'b0;
            exc_s_q   <= 1'b0;
            killed    <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        off_q   <= off;
                        op_q    <= req_op;
                        rdata_q <= '0;
                        killed  <= 1'b0;
                        exc_l_q <= acc_err && !op_is_store(req_op);
                        exc_s_q <= acc_err && op_is_store(req_op);
                        if (!acc_err) begin
                            bus_req   <= 1'b1;
                            bus_we    <= op_is_store(req_op);
                            bus_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            bus_be    <= be_nx;
                            bus_wdata <= wdata_nx;
                        end
                    end
                end
                S_BUSY: begin
                    if (flush) killed <= 1'b1;
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        rdata_q <= bus_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    lsu_ext #(.DATA_W(DATA_W)) u_ext (
        .rdata (rdata_q),
        .op    (op_q),
        .off   (off_q),
        .ext   (ext_data)
    );

    always_comb begin
        resp_valid = (state == S_RESP) && !flush;
        exc_adel   = resp_valid && exc_l_q;
        exc_ades   = resp_valid && exc_s_q;
        resp_rdata = (resp_valid && !op_is_store(op_q) && !exc_l_q) ? ext_data : '0;
    end

endmodule

// File: tb/tb_m_lsu.sv
// tb_m_lsu: directed bench for m_lsu with a per-cycle expectation timeline built from a transaction model.
module tb_m_lsu;
    import lsu_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        flush;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        exc_adel, exc_ades;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    m_lsu #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .exc_adel   (exc_adel),
        .exc_ades   (exc_ades),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          chk;
        bit          ready;
        bit          breq;
        bit          we;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          rv;
        logic [31:0] rd;
        bit          adel;
        bit          ades;
    } exp_t;

    exp_t ex[0:1023];

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [31:0] last_rdata = '0;
    logic [3:0]  last_be = '0;
    logic [31:0] last_wdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic exp_t mk(bit ready, bit breq, bit we, logic [31:0] baddr, logic [3:0] be,
                                logic [31:0] wd, bit rv, logic [31:0] rd, bit adel, bit ades);
        exp_t e;
        e.chk = 1'b1; e.ready = ready; e.breq = breq; e.we = we; e.baddr = baddr;
        e.be = be; e.wd = wd; e.rv = rv; e.rd = rd; e.adel = adel; e.ades = ades;
        return e;
    endfunction

    function automatic exp_t idle_exp();
        return mk(1, 0, 0, '0, '0, '0, 0, '0, 0, 0);
    endfunction

    // compare process: every cycle that has an expectation
    always @(negedge clk) begin
        if (reset_n && cyc < 1024 && ex[cyc].chk) begin
            chk("req_ready", {31'b0, req_ready}, {31'b0, ex[cyc].ready});
            chk("bus_req", {31'b0, bus_req}, {31'b0, ex[cyc].breq});
            if (ex[cyc].breq) begin
                chk("bus_we", {31'b0, bus_we}, {31'b0, ex[cyc].we});
                chk("bus_addr", bus_addr, ex[cyc].baddr);
                chk("bus_be", {28'b0, bus_be}, {28'b0, ex[cyc].be});
                chk("bus_wdata", bus_wdata, ex[cyc].wd);
            end
            chk("resp_valid", {31'b0, resp_valid}, {31'b0, ex[cyc].rv});
            chk("exc_adel", {31'b0, exc_adel}, {31'b0, ex[cyc].adel});
            chk("exc_ades", {31'b0, exc_ades}, {31'b0, ex[cyc].ades});
            if (ex[cyc].rv) chk("resp_rdata", resp_rdata, ex[cyc].rd);
        end
        if (resp_valid) last_rdata = resp_rdata;
        if (bus_req) begin
            last_be = bus_be;
            last_wdata = bus_wdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // delay = BUSY cycles before the ack cycle; flush_off = BUSY index to flush (delay+1 = RESP, -1 none)
    task automatic do_access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                             input int delay, input logic [31:0] rd, input int flush_off);
        int n, sz, m;
        bit err, st, killed;
        logic [3:0]  be;
        logic [31:0] bwd, lane, exp_rd, baddr;
        n  = cyc;
        st = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
        sz = (op == OP_LW || op == OP_SW) ? 4 :
             (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 1;
        err = (addr % sz) != 0;
        if (!((addr <= 32'h2FFF) ||
              (addr >= 32'h7F00 && addr <= 32'h7F0B) ||
              (addr >= 32'h7F10 && addr <= 32'h7F1B))) err = 1;
`ifdef M_LSU_TIMER_GUARD_EN
        if (sz != 4 && addr >= 32'h7F00) err = 1;
`endif
        be    = 4'(((1 << sz) - 1) << (addr % 4));
        bwd   = (sz == 4) ? wd : (sz == 2) ? {2{wd[15:0]}} : {4{wd[7:0]}};
        baddr = addr & 32'hFFFF_FFFC;
        lane  = rd >> (8 * (addr % 4));
        case (op)
            OP_LW:   exp_rd = lane;
            OP_LH:   exp_rd = {{16{lane[15]}}, lane[15:0]};
            OP_LHU:  exp_rd = {16'h0, lane[15:0]};
            OP_LB:   exp_rd = {{24{lane[7]}}, lane[7:0]};
            OP_LBU:  exp_rd = {24'h0, lane[7:0]};
            default: exp_rd = '0;
        endcase

        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        ex[n] = idle_exp();
        step();
        req_valid = 1'b0;
        if (err) begin
            ex[n+1] = mk(0, 0, 0, '0, '0, '0, 1, '0, !st, st);
            ex[n+2] = idle_exp();
            step();
            return;
        end
        killed = 0;
        for (int i = 0; i <= delay; i++) begin
            ex[n+1+i] = mk(0, 1, st, baddr, be, bwd, 0, '0, 0, 0);
            bus_ack   = (i == delay);
            bus_rdata = (i == delay) ? rd : 32'hDEAD_BEEF;
            flush     = (i == flush_off);
            if (flush) killed = 1;
            step();
        end
        bus_ack = 1'b0; flush = 1'b0; bus_rdata = 32'h5555_AAAA;
        m = n + 1 + delay;
        if (killed) begin
            ex[m+1] = idle_exp();
            return;
        end
        if (flush_off == delay + 1) begin
            flush = 1'b1;
            ex[m+1] = mk(0, 0, 0, '0, '0, '0, 0, '0, 0, 0);
        end else begin
            ex[m+1] = mk(0, 0, 0, '0, '0, '0, 1, exp_rd, 0, 0);
        end
        step();
        flush = 1'b0;
        ex[m+2] = idle_exp();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        req_valid = 0; req_op = OP_LW; req_addr = '0; req_wdata = '0;
        flush = 0; bus_ack = 0; bus_rdata = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_exc_adel", {31'b0, exc_adel}, 32'd0);
        chk("rst_exc_ades", {31'b0, exc_ades}, 32'd0);
        chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
        chk("rst_bus_we", {31'b0, bus_we}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_be", {28'b0, bus_be}, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // stray ack in IDLE is ignored
        c = cyc;
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        ex[c] = idle_exp();
        step();
        bus_ack = 1'b0;
        ex[c+1] = idle_exp();
        step();

        do_access(OP_LB, 32'h0000_0003, 32'h0, 2, 32'h80FF_0000, -1);
        step();
        chk("pin_lb_rdata", last_rdata, 32'hFFFF_FF80);

        do_access(OP_SH, 32'h0000_0102, 32'h0000_ABCD, 0, 32'h0, -1);
        step();
        chk("pin_sh_be", {28'b0, last_be}, 32'h0000_000C);
        chk("pin_sh_wdata", last_wdata, 32'hABCD_ABCD);

        do_access(OP_LW, 32'h0000_0006, 32'h0, 0, 32'h0, -1);
        do_access(OP_SW, 32'h0000_4000, 32'h1234_5678, 0, 32'h0, -1);
        do_access(OP_LB, 32'h0000_7F04, 32'h0, 1, 32'h1234_5678, -1);
        do_access(OP_LH, 32'h0000_7F12, 32'h0, 0, 32'h8001_0000, -1);
        do_access(OP_LHU, 32'h0000_0002, 32'h0, 1, 32'h8001_0000, -1);
        step();
        chk("pin_lhu_rdata", last_rdata, 32'h0000_8001);
        do_access(OP_LBU, 32'h0000_0001, 32'h0, 0, 32'h0000_F000, -1);
        do_access(OP_LW, 32'h0000_2FFC, 32'h0, 0, 32'hCAFE_F00D, -1);
        do_access(OP_SB, 32'h0000_0007, 32'h0000_005A, 0, 32'h0, -1);
        do_access(OP_SW, 32'h0000_7F08, 32'h1122_3344, 1, 32'h0, -1);
        do_access(OP_LH, 32'h0000_3001, 32'h0, 0, 32'h0, -1);
        do_access(OP_LW, 32'h0000_3000, 32'h0, 0, 32'h0, -1);
        do_access(OP_LH, 32'h0000_7F0C, 32'h0, 0, 32'h0, -1);
        do_access(OP_SB, 32'h0000_7F1C, 32'h0, 0, 32'h0, -1);
        do_access(OP_SH, 32'h0000_0101, 32'h0, 0, 32'h0, -1);

        // flush in BUSY, then an access right on the IDLE cycle after ack
        do_access(OP_LW, 32'h0000_0010, 32'h0, 3, 32'h1111_1111, 1);
        do_access(OP_LW, 32'h0000_0020, 32'h0, 0, 32'h2222_2222, -1);
        // flush in the RESP cycle
        do_access(OP_LW, 32'h0000_0030, 32'h0, 0, 32'h3333_3333, 1);
        do_access(OP_LH, 32'h0000_0006, 32'h0, 0, 32'h0000_0000, 1);

        // flush with a request in IDLE: not accepted
        c = cyc;
        req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h50; flush = 1'b1;
        ex[c] = idle_exp();
        step();
        req_valid = 1'b0; flush = 1'b0;
        ex[c+1] = idle_exp();
        step();

        // asynchronous reset while BUSY
        req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h40;
        step();
        req_valid = 1'b0;
        #1;
        chk("pre_rst_bus_req", {31'b0, bus_req}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_bus_req", {31'b0, bus_req}, 32'd0);
        chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        do_access(OP_LW, 32'h0000_0044, 32'h0, 0, 32'h0BAD_F00D, -1);
        step();
        chk("pin_post_rst_lw", last_rdata, 32'h0BAD_F00D);
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
